// File: rtl/mix_columns_seq.sv
// AES MixColumns sequencer: reads each of the four state columns, transforms it
// (forward or inverse) and writes it back in place, then pulses done.
module mix_columns_seq #(
  parameter int INV_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        inv,
  output logic        busy,
  output logic        done,
  output logic [1:0]  mat_rd_idx,
  output logic        mat_rd_col,
  input  logic [31:0] mat_rd_data,
  output logic [1:0]  mat_wr_idx,
  output logic        mat_wr_col,
  output logic        mat_we,
  output logic [31:0] mat_wr_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t      state_r;
  logic [1:0]  cnt_r;
  logic        inv_r;
  logic [31:0] col_r;
  logic        busy_r;
  logic        done_r;
  logic        we_r;
  logic [31:0] mc_s;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xtime(a[i]);
      m3[i] = m2[i] ^ a[i];
    end
    return {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
            a[0]  ^ m2[1] ^ m3[2] ^ a[3],
            a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
            m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
  endfunction

  // 09/0B/0D/0E are sums of x, 2x, 4x and 8x, so three xtime stages suffice
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Transform datapath, purely combinational from the captured column
  generate
    if (INV_EN != 0) begin : g_inv
      always_comb begin
        mc_s = inv_r ? mix_inv(col_r) : mix_fwd(col_r);
      end
    end else begin : g_fwd
      always_comb begin
        mc_s = mix_fwd(col_r);
      end
    end
  endgenerate

  // Sequencer FSM with registered control outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
      inv_r   <= 1'b0;
      col_r   <= 32'h0000_0000;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      we_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          we_r   <= 1'b0;
          if (start) begin
            state_r <= RD;
            cnt_r   <= 2'd0;
            inv_r   <= (INV_EN != 0) ? inv : 1'b0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        RD: begin
          col_r   <= mat_rd_data;
          state_r <= WR;
          we_r    <= 1'b1;
        end
        WR: begin
          we_r <= 1'b0;
          if (cnt_r == 2'd3) begin
            state_r <= FIN;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= RD;
            cnt_r   <= cnt_r + 2'd1;
          end
        end
        FIN: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign mat_we      = we_r;
  assign mat_rd_idx  = cnt_r;
  assign mat_wr_idx  = cnt_r;
  assign mat_rd_col  = 1'b1;
  assign mat_wr_col  = 1'b1;
  assign mat_wr_data = mc_s;

endmodule
